ball_collision_tracker: RTL
===========================

Name: ball_collision_tracker

Overview:
- Downstream of the ball motion stage: watches the ball/video signals each frame and extracts the ball's top-left pixel position.
- Emits one-cycle horizontal/vertical bounce events when the ball reaches a playfield edge while moving toward it. These events drive the bounce/move-code registers upstream.
- Also keeps a saturating bounce counter and a lost-ball flag.

Parameters:
LEFT_LIMIT, 4, hbounce when x <= this while moving left
RIGHT_LIMIT, 248, hbounce when x >= this while moving right
TOP_LIMIT, 4, vbounce when y <= this while moving up
BOTTOM_LIMIT, 232, vbounce when y >= this while moving down
COOLDOWN, 2, frames an axis stays suppressed after its bounce (0 = none)
MISS_LIMIT, 3, consecutive ball-less frames before lost asserts (1..15)

Ports:
clk  in  1  pixel clock
ball_reset  in  1  reset, asynchronous, active-high
display_on  in  1  active video
hpos  in  9  pixel column
vpos  in  9  pixel row
vsync  in  1  vertical sync, active-high
ball_gfx  in  1  ball pixel lit
ball_x  out  9  captured ball column
ball_y  out  9  captured ball row
pos_valid  out  1  ball seen in last completed frame
hbounce  out  1  one-cycle horizontal bounce pulse
vbounce  out  1  one-cycle vertical bounce pulse
bounce_count  out  8  saturating total of bounce events
lost  out  1  ball missing for MISS_LIMIT frames
dx  out  5  signed x delta per frame (optional feature)
dy  out  5  signed y delta per frame (optional feature)

Behaviour:
- Reset (ball_reset, asynchronous, active-high; clock clk):
  - Outputs: ball_x = 0, ball_y = 0, pos_valid = 0, hbounce = 0, vbounce = 0, bounce_count = 0, lost = 0, dx = 0, dy = 0.
  - Internal: found = 0, prev_valid = 0, miss_cnt = 0, both cooldown counters = 0, vsync_q = 0, state = WAIT_FRAME.
- Frame edge: vsync_q registers vsync every clk; vs_rise = vsync & ~vsync_q.
- FSM:
  - WAIT_FRAME: on vs_rise, clear found and go to SCAN. No report is made for the partial frame in progress at reset release.
  - SCAN: on the first cycle with display_on & ball_gfx & ~found, capture hpos/vpos into cand_x/cand_y and set found. Later lit pixels are ignored. On vs_rise, go to REPORT.
  - REPORT (exactly one cycle): update outputs at the end of this cycle, clear found, return to SCAN.
  - Latency: hbounce/vbounce/ball_x/ball_y change 2 clk after the cycle where vsync is first sampled high.
- REPORT with found = 1:
  - ball_x/ball_y <= cand; pos_valid <= 1; miss_cnt <= 0; lost <= 0.
  - ddx = cand_x - ball_x and ddy = cand_y - ball_y, computed as 10-bit signed.
  - If prev_valid = 1:
    - hbounce when (ddx > 0 and cand_x >= RIGHT_LIMIT) or (ddx < 0 and cand_x <= LEFT_LIMIT), and the h cooldown is 0.
    - vbounce uses the same rule with ddy, cand_y and the TOP/BOTTOM limits.
    - ddx = 0 never bounces.
  - prev_valid <= 1.
- REPORT with found = 0:
  - pos_valid <= 0; prev_valid <= 0; ball_x/ball_y hold.
  - miss_cnt increments, saturating at 15; lost <= 1 once miss_cnt reaches MISS_LIMIT.
  - No bounce.
- Cooldown:
  - A bounce on an axis loads that axis counter with COOLDOWN.
  - Each REPORT without a bounce on that axis decrements a nonzero counter.
  - Axes are independent.
- Pulses: hbounce/vbounce are high exactly one clk, the cycle after REPORT. Both may pulse in the same cycle.
- bounce_count: adds hbounce + vbounce (0, 1 or 2) and saturates at 255 (254 + 2 = 255).
- Reset mid-frame or mid-pulse: everything is cleared immediately, including any pulse in flight, and the FSM returns to WAIT_FRAME.
- Comparisons are unsigned 9-bit on positions; deltas are signed.

Optional Feature:
- Macro BALL_TRACK_VELOCITY_EN.
- Defined: at each REPORT with found & prev_valid, dx/dy <= ddx/ddy clamped to -16..+15 (5-bit two's complement). Otherwise dx/dy <= 0.
- Undefined: dx/dy are tied to 0, no delta registers are built, and bounce detection is unchanged.

Test Plan:
- Ball at x=100,y=100 in frame 1, x=102,y=101 in frame 2 -> pos_valid=1, ball_x=102, ball_y=101, no bounces; with macro, dx=+2, dy=+1.
- x from 246 to 249 across frames, y constant at 100 -> hbounce pulses exactly 1 clk, bounce_count=1. Next frame x=247 (moving left, cooldown active) -> no pulse.
- Corner: frame 1 (245,229), frame 2 (250,234) -> hbounce and vbounce in the same cycle, bounce_count +2. Preload to 254 -> saturates at 255.
- Ball absent 3 frames -> pos_valid=0 after the first, lost=1 after the third. Ball reappears at x=250 -> no bounce (prev_valid=0), lost=0.
- ball_reset asserted mid-SCAN, then released -> all outputs 0, no report until the second vs_rise after release.
- Two lit pixels in one frame, (50,60) then (51,60) -> capture is (50,60).

Source files
------------

// File: rtl/ball_collision_tracker.sv
// Per-frame ball position capture with edge-bounce pulses, saturating bounce count and lost-ball flag.
// Optional per-frame velocity outputs dx/dy are built only when BALL_TRACK_VELOCITY_EN is defined.
module ball_collision_tracker #(
    parameter int unsigned LEFT_LIMIT   = 4,
    parameter int unsigned RIGHT_LIMIT  = 248,
    parameter int unsigned TOP_LIMIT    = 4,
    parameter int unsigned BOTTOM_LIMIT = 232,
    parameter int unsigned COOLDOWN     = 2,
    parameter int unsigned MISS_LIMIT   = 3
) (
    input  logic       clk,
    input  logic       ball_reset,
    input  logic       display_on,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic       vsync,
    input  logic       ball_gfx,
    output logic [8:0] ball_x,
    output logic [8:0] ball_y,
    output logic       pos_valid,
    output logic       hbounce,
    output logic       vbounce,
    output logic [7:0] bounce_count,
    output logic       lost,
    output logic [4:0] dx,
    output logic [4:0] dy
);

    localparam int unsigned POS_W   = 9;
    localparam int unsigned DELTA_W = 10;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned MISS_W  = 4;
    localparam int unsigned VEL_W   = 5;
    localparam int unsigned CD_W    = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        SCAN       = 2'd1,
        REPORT     = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               vsync_q;
    logic               vs_rise_c;
    logic               found;
    logic [POS_W-1:0]   cand_x, cand_y;
    logic               prev_valid;
    logic [MISS_W-1:0]  miss_cnt;
    logic [CD_W-1:0]    h_cd, v_cd;

    logic signed [DELTA_W-1:0] ddx_c, ddy_c;
    logic               h_toward_c, v_toward_c;
    logic               hb_c, vb_c;
    logic [CNT_W:0]     count_sum_c;
    logic [MISS_W-1:0]  miss_inc_c;

    assign vs_rise_c = vsync & ~vsync_q;

    // State register
    always_ff @(posedge clk or posedge ball_reset) begin
        if (ball_reset) state_q <= WAIT_FRAME;
        else            state_q <= state_d;
    end

    // Next-state logic; REPORT always lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_FRAME: if (vs_rise_c) state_d = SCAN;
            SCAN:       if (vs_rise_c) state_d = REPORT;
            REPORT:     state_d = SCAN;
            default:    state_d = WAIT_FRAME;
        endcase
    end

    // Frame-to-frame deltas and edge-approach decisions
    always_comb begin
        ddx_c = DELTA_W'({1'b0, cand_x}) - DELTA_W'({1'b0, ball_x});
        ddy_c = DELTA_W'({1'b0, cand_y}) - DELTA_W'({1'b0, ball_y});
        h_toward_c = (!ddx_c[DELTA_W-1] && (ddx_c != '0) && (cand_x >= POS_W'(RIGHT_LIMIT)))
                   || (ddx_c[DELTA_W-1] && (cand_x <= POS_W'(LEFT_LIMIT)));
        v_toward_c = (!ddy_c[DELTA_W-1] && (ddy_c != '0) && (cand_y >= POS_W'(BOTTOM_LIMIT)))
                   || (ddy_c[DELTA_W-1] && (cand_y <= POS_W'(TOP_LIMIT)));
        hb_c = found && prev_valid && (h_cd == '0) && h_toward_c;
        vb_c = found && prev_valid && (v_cd == '0) && v_toward_c;
        count_sum_c = (CNT_W+1)'(bounce_count) + (CNT_W+1)'(hb_c) + (CNT_W+1)'(vb_c);
        miss_inc_c  = (miss_cnt == '1) ? miss_cnt : miss_cnt + MISS_W'(1);
    end

    // Capture, report and bookkeeping registers
    always_ff @(posedge clk or posedge ball_reset) begin
        if (ball_reset) begin
            vsync_q      <= 1'b0;
            found        <= 1'b0;
            cand_x       <= '0;
            cand_y       <= '0;
            prev_valid   <= 1'b0;
            miss_cnt     <= '0;
            h_cd         <= '0;
            v_cd         <= '0;
            ball_x       <= '0;
            ball_y       <= '0;
            pos_valid    <= 1'b0;
            hbounce      <= 1'b0;
            vbounce      <= 1'b0;
            bounce_count <= '0;
            lost         <= 1'b0;
        end else begin
            vsync_q <= vsync;
            hbounce <= 1'b0;
            vbounce <= 1'b0;
            case (state_q)
                WAIT_FRAME: begin
                    if (vs_rise_c) found <= 1'b0;
                end
                SCAN: begin
                    if (display_on && ball_gfx && !found) begin
                        cand_x <= hpos;
                        cand_y <= vpos;
                        found  <= 1'b1;
                    end
                end
                REPORT: begin
                    found        <= 1'b0;
                    hbounce      <= hb_c;
                    vbounce      <= vb_c;
                    bounce_count <= count_sum_c[CNT_W] ? '1 : count_sum_c[CNT_W-1:0];
                    if (hb_c)              h_cd <= CD_W'(COOLDOWN);
                    else if (h_cd != '0)   h_cd <= h_cd - CD_W'(1);
                    if (vb_c)              v_cd <= CD_W'(COOLDOWN);
                    else if (v_cd != '0)   v_cd <= v_cd - CD_W'(1);
                    if (found) begin
                        ball_x     <= cand_x;
                        ball_y     <= cand_y;
                        pos_valid  <= 1'b1;
                        prev_valid <= 1'b1;
                        miss_cnt   <= '0;
                        lost       <= 1'b0;
                    end else begin
                        pos_valid  <= 1'b0;
                        prev_valid <= 1'b0;
                        miss_cnt   <= miss_inc_c;
                        if (miss_inc_c >= MISS_W'(MISS_LIMIT)) lost <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BALL_TRACK_VELOCITY_EN
    logic [VEL_W-1:0] dx_q, dy_q;

    function automatic logic [VEL_W-1:0] clamp_vel(input logic signed [DELTA_W-1:0] d);
        if (d < -10'sd16)      return 5'b10000;
        else if (d > 10'sd15)  return 5'b01111;
        else                   return d[VEL_W-1:0];
    endfunction

    // Velocity is only meaningful across two consecutive sightings
    always_ff @(posedge clk or posedge ball_reset) begin
        if (ball_reset) begin
            dx_q <= '0;
            dy_q <= '0;
        end else if (state_q == REPORT) begin
            if (found && prev_valid) begin
                dx_q <= clamp_vel(ddx_c);
                dy_q <= clamp_vel(ddy_c);
            end else begin
                dx_q <= '0;
                dy_q <= '0;
            end
        end
    end

    assign dx = dx_q;
    assign dy = dy_q;
`else
    assign dx = '0;
    assign dy = '0;
`endif

endmodule
